// File: rtl/arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Holds the state encoding, the watchdog default and the winner pick.
package arb_pkg;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam int WAIT_MAX_DEF = 15;

    // A lone request always wins; on a tie the mode decides.
    function automatic logic pick_winner(
        input logic r0,
        input logic r1,
        input logic last,
        input logic fixed
    );
        if (r0 && r1) begin
            return fixed ? 1'b1 : ~last;
        end
        return r1;
    endfunction

endpackage

// File: rtl/mux_32_bit_2_1.sv
// Generic 32-bit two-input multiplexer.
// s=0 selects a, s=1 selects b.
module mux_32_bit_2_1 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        s,
    output logic [31:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single shared memory port.
// Fetch (0) and data (1) take turns; a watchdog bounds each access.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int PRIORITY_MODE = 0,
    parameter int WAIT_MAX      = WAIT_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        busy,
    output logic        err
);

    logic [0:0] state;
    logic       last_grant;
    logic [7:0] wait_cnt;
    logic       in_access;
    logic       limit_hit;

    assign in_access = (state == ACCESS);
    assign limit_hit = (wait_cnt == 8'(WAIT_MAX - 1));

    assign mem_valid = in_access;
    assign busy      = in_access;
    assign mem_we    = (sel ? we1 : we0) & in_access;

    // Completion takes precedence over the watchdog on the same cycle.
    assign ack0  = in_access & mem_ready & ~sel;
    assign ack1  = in_access & mem_ready & sel;
    assign err   = in_access & ~mem_ready & limit_hit;
    assign rdata = mem_rdata;

    mux_32_bit_2_1 u_addr_mux (
        .a (addr0),
        .b (addr1),
        .s (sel),
        .y (mem_addr)
    );

    mux_32_bit_2_1 u_wdata_mux (
        .a (wdata0),
        .b (wdata1),
        .s (sel),
        .y (mem_wdata)
    );

    // Grant on request, hold for one access, always drop back to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        sel      <= pick_winner(req0, req1, last_grant,
                                                PRIORITY_MODE != 0);
                        state    <= ACCESS;
                        wait_cnt <= 8'd0;
                    end
                end
                ACCESS: begin
                    if (mem_ready || limit_hit) begin
                        last_grant <= sel;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// A round-robin and a fixed-priority instance share all inputs.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        we0, we1;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        mem_valid, mem_we, ack0, ack1, sel, busy, err;
    logic [31:0] mem_addr, mem_wdata, rdata;

    logic        f_mem_valid, f_mem_we, f_ack0, f_ack1;
    logic        f_sel, f_busy, f_err;
    logic [31:0] f_mem_addr, f_mem_wdata, f_rdata;

    int checks   = 0;
    int failures = 0;

    logic [2:0] rr_order = 3'b010;

    always #5 clk = ~clk;

    mem_port_arbiter #(.PRIORITY_MODE(0), .WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1),
        .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ack0(ack0), .ack1(ack1), .rdata(rdata),
        .sel(sel), .busy(busy), .err(err)
    );

    mem_port_arbiter #(.PRIORITY_MODE(1), .WAIT_MAX(15)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1),
        .mem_valid(f_mem_valid), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_we(f_mem_we),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ack0(f_ack0), .ack1(f_ack1), .rdata(f_rdata),
        .sel(f_sel), .busy(f_busy), .err(f_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        we0 = 1'b0; we1 = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        tick();
        tick();

        // reset values
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_ack", 32'({ack1, ack0}), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);

        // mem_ready while idle is ignored; rdata is a pass-through
        rst_n = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("idle_ready_ack", 32'({ack1, ack0}), 32'd0);
        chk("rdata_pass", rdata, 32'hCAFE_F00D);
        tick();
        chk("idle_ready_valid", 32'(mem_valid), 32'd0);
        mem_ready = 1'b0;

        // single request, immediate completion
        req0 = 1'b1; addr0 = 32'h0000_0040; wdata0 = 32'h1111_2222;
        #1;
        chk("c1_idle_valid", 32'(mem_valid), 32'd0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("c1_valid", 32'(mem_valid), 32'd1);
        chk("c1_busy", 32'(busy), 32'd1);
        chk("c1_addr", mem_addr, 32'h0000_0040);
        chk("c1_wdata", mem_wdata, 32'h1111_2222);
        chk("c1_we", 32'(mem_we), 32'd0);
        chk("c1_ack0", 32'(ack0), 32'd1);
        chk("c1_ack1", 32'(ack1), 32'd0);
        tick();
        req0 = 1'b0; mem_ready = 1'b0;
        #1;
        chk("c1_bubble", 32'(mem_valid), 32'd0);

        // ties after reset: RR grants 0,1,0; fixed grants 1,1,1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 32'h0000_0100; addr1 = 32'h0000_0200;
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_ready = 1'b1;
            #1;
            chk($sformatf("rr_sel%0d", i), 32'(sel), 32'(rr_order[i]));
            chk($sformatf("rr_addr%0d", i), mem_addr,
                rr_order[i] ? 32'h0000_0200 : 32'h0000_0100);
            chk($sformatf("rr_ack%0d", i), 32'({ack1, ack0}),
                rr_order[i] ? 32'd2 : 32'd1);
            chk($sformatf("fp_sel%0d", i), 32'(f_sel), 32'd1);
            chk($sformatf("fp_ack%0d", i), 32'(f_ack1), 32'd1);
            tick();
            mem_ready = 1'b0;
            if (i == 2) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            #1;
            chk($sformatf("rr_bubble%0d", i), 32'(mem_valid), 32'd0);
            chk($sformatf("fp_bubble%0d", i), 32'(f_mem_valid), 32'd0);
        end

        // watchdog: never ready, abort on the 15th access cycle
        req1 = 1'b1; we1 = 1'b1; wdata1 = 32'hDEAD_BEEF;
        addr1 = 32'h0000_0300;
        tick();
        for (int k = 1; k <= 15; k++) begin
            chk($sformatf("wd_busy%0d", k), 32'(busy), 32'd1);
            chk($sformatf("wd_ack%0d", k), 32'(ack1), 32'd0);
            chk($sformatf("wd_err%0d", k), 32'(err),
                (k == 15) ? 32'd1 : 32'd0);
            if (k == 1) begin
                chk("wd_we", 32'(mem_we), 32'd1);
                chk("wd_wdata", mem_wdata, 32'hDEAD_BEEF);
                chk("wd_sel", 32'(sel), 32'd1);
            end
            if (k < 15) tick();
        end
        tick();
        req1 = 1'b0; we1 = 1'b0;
        #1;
        chk("wd_idle", 32'(mem_valid), 32'd0);
        chk("wd_err_after", 32'(err), 32'd0);

        // ready coincides with the watchdog limit: completion wins
        req0 = 1'b1; addr0 = 32'h0000_0400;
        tick();
        for (int k = 1; k <= 14; k++) begin
            chk($sformatf("co_ack%0d", k), 32'(ack0), 32'd0);
            chk($sformatf("co_err%0d", k), 32'(err), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("co_ack15", 32'(ack0), 32'd1);
        chk("co_err15", 32'(err), 32'd0);
        tick();
        mem_ready = 1'b0; req0 = 1'b0;
        #1;
        chk("co_idle", 32'(mem_valid), 32'd0);

        // reset in the 2nd access cycle abandons the transaction
        req1 = 1'b1; addr1 = 32'h0000_0500;
        tick();
        chk("ra_sel1", 32'(sel), 32'd1);
        tick();
        chk("ra_valid2", 32'(mem_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("ra_valid", 32'(mem_valid), 32'd0);
        chk("ra_ack", 32'({ack1, ack0}), 32'd0);
        chk("ra_err", 32'(err), 32'd0);
        chk("ra_sel", 32'(sel), 32'd0);
        rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1;
        tick();
        chk("ra_tie_sel", 32'(sel), 32'd0);
        chk("ra_tie_fp", 32'(f_sel), 32'd1);
        mem_ready = 1'b1;
        #1;
        chk("ra_tie_ack", 32'(ack0), 32'd1);
        tick();
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
